vip_pattern_gen: RTL and testbench

Synthesizable, parametrised successor to the bench-only image generator. It produces `num_frame` frames of `width` x `height` pixels, in one of four test patterns, into a downstream FIFO write port with `fifo_full` backpressure. It sits in front of `vip_top` on the FPGA, so the pipeline can be exercised without a file-based source. It adds multi-channel pixels, selectable patterns, an inter-frame gap and an abort.

---
 rtl/vip_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_vip_pattern_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vip_pattern_gen.sv
// Parametrised test-pattern source (SOLID/RAMP/CHECKER/BARS) feeding a FIFO write port.
// Optional start-of-frame marker enabled by defining VIP_PATGEN_SOF_MARKER_EN.
module vip_pattern_gen #(
  parameter int unsigned       DWIDTH      = 24,
  parameter int unsigned       CHANNELS    = 3,
  parameter int unsigned       DIMW        = 11,
  parameter int unsigned       GAP_CYCLES  = 0,
  parameter logic [DWIDTH-1:0] SOLID_VALUE = DWIDTH'(24'h808080)
`ifdef VIP_PATGEN_SOF_MARKER_EN
  ,
  parameter logic [DWIDTH-1:0] MARKER_VALUE = DWIDTH'(24'hFF00FF)
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DIMW-1:0]   width,
  input  logic [DIMW-1:0]   height,
  input  logic [DIMW-1:0]   num_frame,
  input  logic              fifo_full,
  output logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_wrreq,
  output logic              busy,
  output logic              frame_done,
  output logic              run_done
);

  localparam int unsigned CW = DWIDTH / CHANNELS;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_l;
  logic [DIMW-1:0]   width_l, height_l, nframe_l;
  logic [DIMW-1:0]   x, y, f, bar_cnt, bar_len;
  logic [2:0]        bar;
  logic [7:0]        gap_cnt;
  logic              wr, last_x, last_y, last_f, last_bar, zero_dim;
  logic [CW-1:0]     ramp_val;
  logic [DWIDTH-1:0] ramp_word, bar_word, pix;

  assign last_x   = (x == width_l - DIMW'(1));
  assign last_y   = (y == height_l - DIMW'(1));
  assign last_f   = (f == nframe_l - DIMW'(1));
  assign zero_dim = (width_l == '0) || (height_l == '0) || (nframe_l == '0);
  assign bar_len  = ((width_l >> 3) == '0) ? DIMW'(1) : (width_l >> 3);
  assign last_bar = (bar_cnt == bar_len - DIMW'(1));

  assign fifo_wrreq = wr;
  assign busy       = (state != IDLE);
  assign run_done   = (state == DONE) && !abort;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and write strobe; abort overrides everything
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = zero_dim ? DONE : RUN;
      RUN: begin
        wr = !fifo_full;
        if (wr && last_x && last_y)
          state_nxt = last_f ? DONE : ((GAP_CYCLES == 0) ? RUN : GAP);
      end
      GAP:  if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nxt = RUN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      wr        = 1'b0;
    end
  end

  // Latched configuration, pixel/line/frame counters and bar tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_l     <= '0;
      width_l    <= '0;
      height_l   <= '0;
      nframe_l   <= '0;
      x          <= '0;
      y          <= '0;
      f          <= '0;
      bar_cnt    <= '0;
      bar        <= '0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wr && last_x && last_y;
      case (state)
        IDLE: if (start && !abort) begin
          mode_l   <= mode;
          width_l  <= width;
          height_l <= height;
          nframe_l <= num_frame;
        end
        LOAD: begin
          x       <= '0;
          y       <= '0;
          f       <= '0;
          bar_cnt <= '0;
          bar     <= '0;
          gap_cnt <= '0;
        end
        RUN: if (wr) begin
          gap_cnt <= '0;
          if (last_x) begin
            x       <= '0;
            bar     <= '0;
            bar_cnt <= '0;
            if (last_y) begin
              y <= '0;
              if (!last_f) f <= f + DIMW'(1);
            end else begin
              y <= y + DIMW'(1);
            end
          end else begin
            x <= x + DIMW'(1);
            if (last_bar) begin
              bar_cnt <= '0;
              if (bar != 3'd7) bar <= bar + 3'd1;
            end else begin
              bar_cnt <= bar_cnt + DIMW'(1);
            end
          end
        end
        GAP: gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign ramp_val = CW'(x + y + f);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ramp_word[c*CW +: CW] = ramp_val;
    assign bar_word[c*CW +: CW]  = {CW{bar[c % 3]}};
  end

  // Pixel generator; output forced to zero outside RUN
  always_comb begin
    pix = '0;
    case (mode_l)
      2'd0:    pix = SOLID_VALUE;
      2'd1:    pix = ramp_word;
      2'd2:    pix = {DWIDTH{x[3] ^ y[3]}};
      default: pix = bar_word;
    endcase
`ifdef VIP_PATGEN_SOF_MARKER_EN
    if ((x == '0) && (y == '0)) pix = MARKER_VALUE;
`endif
    fifo_data = (state == RUN) ? pix : '0;
  end

endmodule

// File: tb/tb_vip_pattern_gen.sv
// Scoreboard bench for vip_pattern_gen: stimulus pushes expected pixels, a monitor pops on each write.
module tb_vip_pattern_gen;

  localparam int GAP = 3;

  logic        clock = 1'b0;
  logic        reset, start, abort, fifo_full;
  logic [1:0]  mode;
  logic [10:0] width, height, num_frame;
  logic [23:0] fifo_data;
  logic        fifo_wrreq, busy, frame_done, run_done;

  typedef struct {
    logic [23:0] d;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, wr_cnt = 0, fd_cnt = 0, rd_cnt = 0, fd_cyc = -1, rd_cyc = -1;

  vip_pattern_gen #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .width(width), .height(height), .num_frame(num_frame), .fifo_full(fifo_full),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .busy(busy),
    .frame_done(frame_done), .run_done(run_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit before the rising edge
  always @(negedge clock) begin
    exp_t e;
    #4;
    if (fifo_wrreq) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got data %0h with empty scoreboard (cycle %0d)", fifo_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("pixel_data", fifo_data, e.d);
        if (e.cyc >= 0) chk("pixel_cycle", cyc, e.cyc);
      end
    end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (run_done)   begin rd_cnt++; rd_cyc = cyc; end
  end

  function automatic logic [23:0] exp_pix(input int m, input int x, input int y, input int f, input int w);
    int b, bl, v;
    logic [23:0] r;
    case (m)
      0: r = 24'h808080;
      1: begin v = (x + y + f) % 256; r = {8'(v), 8'(v), 8'(v)}; end
      2: r = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: begin
        bl = (w / 8 > 0) ? w / 8 : 1;
        b  = x / bl;
        if (b > 7) b = 7;
        case (b)
          0: r = 24'h000000; 1: r = 24'h0000FF; 2: r = 24'h00FF00; 3: r = 24'h00FFFF;
          4: r = 24'hFF0000; 5: r = 24'hFF00FF; 6: r = 24'hFFFF00; default: r = 24'hFFFFFF;
        endcase
      end
    endcase
`ifdef VIP_PATGEN_SOF_MARKER_EN
    if (x == 0 && y == 0) r = 24'hFF00FF;
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push_run(input int m, input int w, input int h, input int n, input int c0, input bit timed);
    exp_t e;
    for (int f = 0; f < n; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          e.d   = exp_pix(m, x, y, f, w);
          e.cyc = timed ? c0 + 2 + f * (w * h + GAP) + y * w + x : -1;
          sb.push_back(e);
        end
  endtask

  task automatic do_start(input int m, input int w, input int h, input int n, output int c0);
    mode = 2'(m); width = 11'(w); height = 11'(h); num_frame = 11'(n);
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_counts();
    wr_cnt = 0; fd_cnt = 0; rd_cnt = 0; fd_cyc = -1; rd_cyc = -1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk({nm, "_idle_timeout"}, busy, 0);
  endtask

  task automatic end_run(input string nm, input int nw, input int nfd, input int nrd);
    chk({nm, "_writes"}, wr_cnt, nw);
    chk({nm, "_sb_left"}, sb.size(), 0);
    chk({nm, "_frame_done_cnt"}, fd_cnt, nfd);
    chk({nm, "_run_done_cnt"}, rd_cnt, nrd);
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    mode = '0; width = '0; height = '0; num_frame = '0;
    repeat (3) tick();
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_data", fifo_data, 0);
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_data_after", fifo_data, 0);

    // 1: SOLID 4x2, one frame; a start while busy must be ignored
    clear_counts();
    do_start(0, 4, 2, 1, c0);
    push_run(0, 4, 2, 1, c0, 1'b1);
    tick(); tick();
    mode = 2'd1; width = 11'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t1", 200);
    end_run("t1", 8, 1, 1);
    chk("t1_frame_done_cycle", fd_cyc, c0 + 10);
    chk("t1_run_done_cycle", rd_cyc, c0 + 10);

    // 2: RAMP 16x1, two frames with inter-frame gap
    clear_counts();
    do_start(1, 16, 1, 2, c0);
    push_run(1, 16, 1, 2, c0, 1'b1);
    wait_idle("t2", 300);
    end_run("t2", 32, 2, 1);

    // 3: BARS width 16 with fifo_full toggling every cycle
    clear_counts();
    do_start(3, 16, 1, 1, c0);
    push_run(3, 16, 1, 1, c0, 1'b0);
    for (int i = 0; i < 400 && busy; i++) begin
      fifo_full = ~fifo_full;
      tick();
    end
    fifo_full = 1'b0;
    wait_idle("t3", 10);
    end_run("t3", 16, 1, 1);

    // 4: zero dimensions, then start+abort together in IDLE
    clear_counts();
    do_start(1, 0, 2, 1, c0);
    wait_idle("t4a", 50);
    chk("t4a_run_done_cycle", rd_cyc, c0 + 2);
    end_run("t4a", 0, 0, 1);
    clear_counts();
    do_start(0, 4, 4, 0, c0);
    wait_idle("t4b", 50);
    chk("t4b_run_done_cycle", rd_cyc, c0 + 2);
    end_run("t4b", 0, 0, 1);
    clear_counts();
    abort = 1'b1;
    do_start(0, 4, 2, 1, c0);
    abort = 1'b0;
    chk("t4c_busy", busy, 0);
    repeat (10) tick();
    end_run("t4c", 0, 0, 0);

    // 5: abort after 5 pixels, reset mid-frame, then a clean full frame
    clear_counts();
    do_start(1, 8, 8, 1, c0);
    push_run(1, 5, 1, 1, c0, 1'b1);
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5a_busy", busy, 0);
    repeat (5) tick();
    end_run("t5a", 5, 0, 0);
    clear_counts();
    do_start(1, 8, 8, 1, c0);
    push_run(1, 3, 1, 1, c0, 1'b1);
    repeat (4) tick();
    reset = 1'b1; fifo_full = 1'b1;
    tick();
    reset = 1'b0; fifo_full = 1'b0;
    chk("t5b_busy", busy, 0);
    chk("t5b_wrreq", fifo_wrreq, 0);
    repeat (5) tick();
    end_run("t5b", 3, 0, 0);
    clear_counts();
    do_start(1, 8, 8, 1, c0);
    push_run(1, 8, 8, 1, c0, 1'b1);
    wait_idle("t5c", 300);
    end_run("t5c", 64, 1, 1);

    // 6: CHECKER 8x2 two frames, then 16x9 to exercise both checker bits
    clear_counts();
    do_start(2, 8, 2, 2, c0);
    push_run(2, 8, 2, 2, c0, 1'b1);
    wait_idle("t6a", 300);
    end_run("t6a", 32, 2, 1);
    clear_counts();
    do_start(2, 16, 9, 1, c0);
    push_run(2, 16, 9, 1, c0, 1'b1);
    wait_idle("t6b", 500);
    end_run("t6b", 144, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1);
  end

endmodule
